fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle datapath. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake, with one request outstanding at a time. Fetched {pc, instruction} pairs are buffered in a small FIFO and presented to the datapath with valid/ready. A redirect from the datapath (taken branch/jump) flushes the buffer and discards any in-flight response.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
DEPTH, 2, FIFO entries; power of two, at least 2
NOP, 32'h00000013, instruction driven when o_valid=0 (addi x0,x0,0)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
redirect  input  1  datapath requests a PC change
redirect_pc  input  32  new fetch target; bits[1:0] ignored and forced to 0
mem_req  output  1  instruction read request
mem_addr  output  32  word address of request (fpc)
mem_gnt  input  1  memory accepts request this cycle (only meaningful with mem_req)
mem_rvalid  input  1  read data valid, at least 1 cycle after grant
mem_rdata  input  32  read data
o_valid  output  1  head FIFO entry valid
o_pc  output  32  PC of head entry (0 when !o_valid)
o_instruction  output  32  head instruction (NOP when !o_valid)
i_ready  input  1  datapath consumes head entry

Behaviour:
- State: fpc[31:0], req_pc[31:0], FSM {REQ, WAIT, DROP}, FIFO of DEPTH {pc, instr} entries, count 0..DEPTH.
- Reset: fpc=RESET_PC, FSM=REQ, count=0, FIFO pointers 0; mem_req=0, o_valid=0, o_pc=0, o_instruction=NOP during the reset cycle. The memory shares reset; responses from before reset are not expected.
- mem_req = (state==REQ) & (count<DEPTH) & !redirect & !reset. This is combinational; mem_addr=fpc at all times.
- REQ: on mem_req&mem_gnt, req_pc<=fpc, fpc<=fpc+4 (wraps modulo 2^32), go WAIT. Without grant, hold mem_req and mem_addr stable.
- WAIT: on mem_rvalid, push {req_pc, mem_rdata} and go REQ. Space is guaranteed because a request is issued only when count<DEPTH.
- DROP: on mem_rvalid, discard the data and go REQ.
- Redirect has highest priority, applied at the clock edge:
  - FIFO is flushed (count=0, pointers reset).
  - fpc<={redirect_pc[31:2],2'b00}.
  - From REQ: stay REQ; no request is issued that cycle.
  - From WAIT without rvalid: go DROP.
  - From WAIT with rvalid the same cycle: no push, go REQ.
  - From DROP: stay DROP, or go REQ if rvalid arrives the same cycle.
- Output: o_valid=(count!=0); o_pc/o_instruction come from the FIFO head register, with no combinational path from mem_rdata.
- Pop on o_valid&i_ready. Push and pop in the same cycle leave count unchanged. A pop coinciding with redirect is overridden by the flush.
- i_ready while !o_valid: no effect.
- Latency:
  - First mem_req occurs the first cycle reset is low, addr RESET_PC.
  - Entry becomes visible (o_valid=1) the cycle after mem_rvalid.
  - With 1-cycle memory and i_ready=1, peak throughput is one instruction per 2 cycles.
- After redirect: first new request is issued the next cycle (from REQ), or the cycle after the discarded response (from WAIT/DROP).
- mem_rvalid in REQ: protocol violation, ignored.

Test Plan:
1. Reset release, gnt immediate, rvalid 1 cycle later with rdata=32'h00500093, i_ready=1 -> mem_addr=0 then 4, o_valid with o_pc=0, o_instruction=32'h00500093; next entry o_pc=4.
2. i_ready=0, memory always ready -> exactly DEPTH=2 entries fetched (pc 0,4), then mem_req stays 0. Raise i_ready -> pc 0,4 drain in order, fetching resumes at 8.
3. mem_gnt held low 3 cycles -> mem_req and mem_addr=0 stable throughout, no state change, fpc still 0 until grant.
4. Redirect to 32'h00000103 while in WAIT, rvalid 2 cycles later -> that response is dropped, no o_valid; next mem_addr=32'h00000100, and the first delivered o_pc=32'h100.
5. Redirect in the same cycle as rvalid and a pop with FIFO holding 1 entry -> count=0, o_valid=0 next cycle, o_instruction=NOP, next request at the redirect target.
6. fpc=32'hFFFFFFFC fetched -> next mem_addr=32'h00000000 (wrap). Reset asserted during WAIT -> mem_req=0, o_valid=0, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word reads into a small {pc, instr} FIFO,
// with redirect flushing the buffer and dropping any in-flight response.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instruction,
   input  logic        i_ready
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [31:0]   fpc_q, fpc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   pc_mem_q  [DEPTH];
   logic [31:0]   ins_mem_q [DEPTH];
   logic          push, pop;

   assign mem_req  = (state_q == S_REQ) && (count_q < FULL) && !redirect && !reset;
   assign mem_addr = fpc_q;

   assign o_valid       = (count_q != '0) && !reset;
   assign o_pc          = o_valid ? pc_mem_q[rptr_q]  : '0;
   assign o_instruction = o_valid ? ins_mem_q[rptr_q] : NOP;

   always_comb begin
      fpc_d    = fpc_q;
      req_pc_d = req_pc_q;
      state_d  = state_q;
      push     = 1'b0;
      pop      = o_valid && i_ready;

      case (state_q)
         S_REQ: begin
            if (mem_req && mem_gnt) begin
               req_pc_d = fpc_q;
               fpc_d    = fpc_q + 32'd4;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               push    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (mem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      // Redirect overrides push/pop; an unanswered request must be drained via DROP.
      if (redirect) begin
         fpc_d = redirect_pc & 32'hFFFF_FFFC;
         push  = 1'b0;
         pop   = 1'b0;
         if (state_q == S_WAIT && !mem_rvalid) state_d = S_DROP;
      end

      if (redirect) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
         rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fpc_q    <= RESET_PC;
         req_pc_q <= '0;
         state_q  <= S_REQ;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
      end else begin
         fpc_q    <= fpc_d;
         req_pc_q <= req_pc_d;
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem_q[wptr_q]  <= req_pc_q;
         ins_mem_q[wptr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a behavioural instruction memory with a grant budget
// and response delay, directed scenarios, and a monitor comparing delivered entries in order.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [31:0] o_instruction;
   logic        i_ready;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int          budget   = 0;
   int          rv_delay = 1;
   logic [63:0] exp_q [$];

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2), .NOP(32'h0000_0013)) dut (
      .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .o_valid(o_valid), .o_pc(o_pc), .o_instruction(o_instruction), .i_ready(i_ready)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0093 + a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic set_budget(input int n);
      budget  = n;
      mem_gnt = (n != 0);
   endtask

   task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
      exp_q.push_back({pc, ins});
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL %s: %0d entries still expected, required 0", name, exp_q.size());
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      i_ready  = 1'b0;
      set_budget(0);
      step();
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_o_pc", o_pc, 32'd0);
      chk("rst_o_instr", o_instruction, NOP);
      step();
   endtask

   // Instruction memory: one request at a time, rvalid rv_delay cycles after grant.
   initial begin
      automatic logic        g, rsv, pend = 1'b0;
      automatic logic [31:0] ga, paddr = '0;
      automatic int          cnt = 0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clock);
         g   = mem_req && mem_gnt && !reset;
         ga  = mem_addr;
         rsv = reset;
         @(posedge clock);
         #1;
         mem_rvalid = 1'b0;
         if (rsv) begin
            pend = 1'b0;
         end else begin
            if (g) begin
               pend  = 1'b1;
               cnt   = rv_delay;
               paddr = ga;
               if (budget > 0) budget--;
               mem_gnt = (budget != 0);
            end
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = mem_word(paddr);
                  pend       = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: every accepted head entry must match the next expected one.
   initial begin
      automatic logic [63:0] e;
      forever begin
         @(negedge clock);
         if (!reset && !redirect && o_valid && i_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_entry: got pc %h instr %h, required no entry", o_pc, o_instruction);
            end else begin
               e = exp_q.pop_front();
               if ({o_pc, o_instruction} === e) n_pass++;
               else $display("FAIL entry: got pc %h instr %h, required pc %h instr %h",
                             o_pc, o_instruction, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      i_ready     = 1'b0;
      mem_gnt     = 1'b0;

      // 1: basic fetch, immediate grant, 1-cycle response
      do_reset();
      expect_entry(32'h0, 32'h0050_0093);
      expect_entry(32'h4, 32'h0050_0097);
      reset = 1'b0; i_ready = 1'b1; rv_delay = 1; set_budget(2);
      #1;
      chk("t1_req0", {31'd0, mem_req}, 32'd1);
      chk("t1_addr0", mem_addr, 32'h0);
      step(); #1;
      chk("t1_wait_noreq", {31'd0, mem_req}, 32'd0);
      step(); #1;
      chk("t1_valid", {31'd0, o_valid}, 32'd1);
      chk("t1_addr4", mem_addr, 32'h4);
      drain("t1_drain");

      // 2: backpressure fills the FIFO, then drains in order
      do_reset();
      reset = 1'b0; rv_delay = 1; set_budget(10);
      for (int i = 0; i < 6; i++) step();
      #1;
      chk("t2_full_noreq", {31'd0, mem_req}, 32'd0);
      chk("t2_head_pc", o_pc, 32'h0);
      chk("t2_grants", budget, 8);
      expect_entry(32'h0, 32'h0050_0093);
      expect_entry(32'h4, 32'h0050_0097);
      expect_entry(32'h8, 32'h0050_009B);
      step();
      set_budget(1); i_ready = 1'b1;
      drain("t2_drain");

      // 3: grant withheld, request held stable
      do_reset();
      reset = 1'b0; i_ready = 1'b1; rv_delay = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_req_held", {31'd0, mem_req}, 32'd1);
         chk("t3_addr_held", mem_addr, 32'h0);
         chk("t3_no_valid", {31'd0, o_valid}, 32'd0);
         step();
      end
      expect_entry(32'h0, 32'h0050_0093);
      set_budget(1);
      drain("t3_drain");

      // 4: redirect while waiting; late response is dropped
      do_reset();
      expect_entry(32'h100, 32'h0050_0193);
      reset = 1'b0; i_ready = 1'b1; rv_delay = 2; set_budget(1);
      step();
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      #1;
      chk("t4_redir_noreq", {31'd0, mem_req}, 32'd0);
      step();
      redirect = 1'b0; set_budget(1);
      #1;
      chk("t4_drop_noreq", {31'd0, mem_req}, 32'd0);
      step(); #1;
      chk("t4_req", {31'd0, mem_req}, 32'd1);
      chk("t4_addr", mem_addr, 32'h100);
      chk("t4_no_valid", {31'd0, o_valid}, 32'd0);
      drain("t4_drain");

      // 5: redirect coinciding with rvalid and pop, one entry buffered
      do_reset();
      reset = 1'b0; rv_delay = 1; set_budget(2);
      for (int i = 0; i < 10 && !(mem_rvalid && o_valid); i++) step();
      chk("t5_setup", {30'd0, mem_rvalid, o_valid}, 32'd3);
      expect_entry(32'h200, 32'h0050_0293);
      redirect = 1'b1; redirect_pc = 32'h0000_0200; i_ready = 1'b1;
      step();
      redirect = 1'b0; set_budget(1);
      #1;
      chk("t5_flush_valid", {31'd0, o_valid}, 32'd0);
      chk("t5_flush_nop", o_instruction, NOP);
      chk("t5_flush_pc", o_pc, 32'h0);
      chk("t5_req", {31'd0, mem_req}, 32'd1);
      chk("t5_addr", mem_addr, 32'h200);
      drain("t5_drain");

      // 6: PC wrap, then reset during an outstanding request
      do_reset();
      reset = 1'b0; i_ready = 1'b1; rv_delay = 1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      #1;
      chk("t6_redir_noreq", {31'd0, mem_req}, 32'd0);
      step();
      redirect = 1'b0;
      expect_entry(32'hFFFF_FFFC, 32'h0050_008F);
      set_budget(1);
      #1;
      chk("t6_addr_top", mem_addr, 32'hFFFF_FFFC);
      drain("t6_wrap_drain");
      #1;
      chk("t6_addr_wrap", mem_addr, 32'h0);
      rv_delay = 3; set_budget(1);
      step(); #1;
      chk("t6_wait_noreq", {31'd0, mem_req}, 32'd0);
      reset = 1'b1;
      #0.5;
      chk("t6_rst_req", {31'd0, mem_req}, 32'd0);
      chk("t6_rst_valid", {31'd0, o_valid}, 32'd0);
      step(); step();
      reset = 1'b0; rv_delay = 1; set_budget(1);
      expect_entry(32'h0, 32'h0050_0093);
      #1;
      chk("t6_restart_addr", mem_addr, 32'h0);
      chk("t6_restart_req", {31'd0, mem_req}, 32'd1);
      drain("t6_restart_drain");

      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
